// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: ALU ops, opcodes, FSM states and
// datapath mux selects, plus the packed control word the FSM drives each cycle.
package multicycle_ctrl_pkg;

  localparam logic [3:0] ALU_CTRL_ADD   = 4'd0;
  localparam logic [3:0] ALU_CTRL_SUB   = 4'd1;
  localparam logic [3:0] ALU_CTRL_SLL   = 4'd2;
  localparam logic [3:0] ALU_CTRL_SLT   = 4'd3;
  localparam logic [3:0] ALU_CTRL_SLTU  = 4'd4;
  localparam logic [3:0] ALU_CTRL_XOR   = 4'd5;
  localparam logic [3:0] ALU_CTRL_SRL   = 4'd6;
  localparam logic [3:0] ALU_CTRL_SRA   = 4'd7;
  localparam logic [3:0] ALU_CTRL_OR    = 4'd8;
  localparam logic [3:0] ALU_CTRL_AND   = 4'd9;
  localparam logic [3:0] ALU_CTRL_LUI   = 4'd10;
  localparam logic [3:0] ALU_CTRL_AUIPC = 4'd11;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] PC_SEL_PC4          = 2'd0;
  localparam logic [1:0] PC_SEL_ALU          = 2'd1;
  localparam logic [1:0] PC_SEL_ALUREG       = 2'd2;
  localparam logic [1:0] PC_SEL_ALUREG_ALIGN = 2'd3;

  localparam logic [1:0] WB_SEL_ALUREG = 2'd0;
  localparam logic [1:0] WB_SEL_MEM    = 2'd1;
  localparam logic [1:0] WB_SEL_PC4    = 2'd2;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       alu_out_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       retired;
  } ctrl_t;

  // BEQ/BNE test the zero flag; the four compare branches test the SLT/SLTU bit.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic lt);
    return funct3[2] ? (lt ^ funct3[0]) : (zero ^ funct3[0]);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational map from (opcode, funct3, funct7[5]) to the ALU op and an instruction-legal bit.
// Zero latency; no handshake.
module multicycle_ctrl_alu_op_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_ctrl,
  output logic       legal
);

  logic [3:0] arith;

  // funct3 table shared by OP and OP-IMM; only OP uses funct7[5] to pick SUB.
  always_comb begin
    arith = ALU_CTRL_ADD;
    case (funct3)
      3'b000:  arith = ALU_CTRL_ADD;
      3'b001:  arith = ALU_CTRL_SLL;
      3'b010:  arith = ALU_CTRL_SLT;
      3'b011:  arith = ALU_CTRL_SLTU;
      3'b100:  arith = ALU_CTRL_XOR;
      3'b101:  arith = funct7_b5 ? ALU_CTRL_SRA : ALU_CTRL_SRL;
      3'b110:  arith = ALU_CTRL_OR;
      default: arith = ALU_CTRL_AND;
    endcase
  end

  always_comb begin
    alu_ctrl = ALU_CTRL_ADD;
    legal    = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal    = 1'b1;
        alu_ctrl = (funct3 == 3'b000 && funct7_b5) ? ALU_CTRL_SUB : arith;
      end
      OPC_OP_IMM: begin
        legal    = 1'b1;
        alu_ctrl = arith;
      end
      OPC_LUI: begin
        legal    = 1'b1;
        alu_ctrl = ALU_CTRL_LUI;
      end
      OPC_AUIPC: begin
        legal    = 1'b1;
        alu_ctrl = ALU_CTRL_AUIPC;
      end
      OPC_LOAD:  legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      OPC_STORE: legal = funct3 inside {3'b000, 3'b001, 3'b010};
      OPC_BRANCH: begin
        legal = (funct3[2:1] != 2'b01);
        if (funct3[2] == 1'b0)
          alu_ctrl = ALU_CTRL_SUB;
        else
          alu_ctrl = funct3[1] ? ALU_CTRL_SLTU : ALU_CTRL_SLT;
      end
      OPC_JAL:  legal = 1'b1;
      OPC_JALR: legal = (funct3 == 3'b000);
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM; 3-5 cycles per instruction with zero-wait memory, held in FETCH/MEM while mem_ready is low.
// Strobes are a decode of state and instr; only state and the sticky illegal flag are registered.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE     = S_FETCH,
  parameter bit     TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zeroFlag,
  input  logic        alu_lsb,
  input  logic        mem_ready,
  output logic [3:0]  ALUCtrl,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        alu_out_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        illegal,
  output logic        retired,
  output logic [2:0]  state
);

  state_t     cur, nxt;
  ctrl_t      c;
  logic       illegal_q;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] dec_alu_ctrl;
  logic       dec_legal;
  logic       is_load, is_store, is_jalr;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign is_load      = (opcode == OPC_LOAD);
  assign is_store     = (opcode == OPC_STORE);
  assign is_jalr      = (opcode == OPC_JALR);
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  multicycle_ctrl_alu_op_decode u_alu_op_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7_b5 (instr[30]),
    .alu_ctrl  (dec_alu_ctrl),
    .legal     (dec_legal)
  );

  always_comb begin
    // All-zero control word is the idle default: ADD, RS1/RS2, PC4, ALUREG, no strobes.
    c   = '0;
    nxt = cur;
    case (cur)
      S_FETCH: begin
        c.mem_req      = 1'b1;
        c.mem_addr_sel = 1'b0;
        if (mem_ready) begin
          c.ir_we = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          nxt = S_EXEC;
        end else if (TRAP_ON_ILLEGAL) begin
          nxt = S_TRAP;
        end else begin
          c.pc_we   = 1'b1;
          c.pc_sel  = PC_SEL_PC4;
          c.retired = 1'b1;
          nxt       = S_FETCH;
        end
      end
      S_EXEC: begin
        c.alu_out_we = 1'b1;
        c.alu_ctrl   = dec_alu_ctrl;
        case (opcode)
          OPC_OP: nxt = S_WB;
          OPC_OP_IMM: begin
            c.src_b = SRC_B_IMM;
            nxt     = S_WB;
          end
          OPC_LUI: begin
            c.src_a = SRC_A_ZERO;
            c.src_b = SRC_B_IMM;
            nxt     = S_WB;
          end
          OPC_AUIPC: begin
            c.src_a = SRC_A_PC;
            c.src_b = SRC_B_IMM;
            nxt     = S_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            c.src_b = SRC_B_IMM;
            nxt     = S_MEM;
          end
          OPC_BRANCH: begin
            // Compare result is live from the ALU this cycle; not-taken retires immediately.
            if (branch_taken(funct3, zeroFlag, alu_lsb)) begin
              nxt = S_BRANCH;
            end else begin
              c.pc_we   = 1'b1;
              c.pc_sel  = PC_SEL_PC4;
              c.retired = 1'b1;
              nxt       = S_FETCH;
            end
          end
          OPC_JAL: begin
            c.src_a = SRC_A_PC;
            c.src_b = SRC_B_IMM;
            nxt     = S_JUMP;
          end
          OPC_JALR: begin
            c.src_b = SRC_B_IMM;
            nxt     = S_JUMP;
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        c.mem_req      = 1'b1;
        c.mem_addr_sel = 1'b1;
        c.mem_we       = is_store;
        c.wb_sel       = is_store ? WB_SEL_ALUREG : WB_SEL_MEM;
        if (mem_ready) begin
          if (is_store) begin
            c.pc_we   = 1'b1;
            c.pc_sel  = PC_SEL_PC4;
            c.retired = 1'b1;
            nxt       = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        c.reg_we  = 1'b1;
        c.wb_sel  = is_load ? WB_SEL_MEM : WB_SEL_ALUREG;
        c.pc_we   = 1'b1;
        c.pc_sel  = PC_SEL_PC4;
        c.retired = 1'b1;
        nxt       = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_ctrl = ALU_CTRL_ADD;
        c.src_a    = SRC_A_PC;
        c.src_b    = SRC_B_IMM;
        c.pc_we    = 1'b1;
        c.pc_sel   = PC_SEL_ALU;
        c.retired  = 1'b1;
        nxt        = S_FETCH;
      end
      S_JUMP: begin
        c.reg_we  = 1'b1;
        c.wb_sel  = WB_SEL_PC4;
        c.pc_we   = 1'b1;
        c.pc_sel  = is_jalr ? PC_SEL_ALUREG_ALIGN : PC_SEL_ALUREG;
        c.retired = 1'b1;
        nxt       = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = RESET_STATE;
    endcase

    // Reset kills every strobe in the same cycle, abandoning any memory access.
    if (rst) begin
      c.ir_we      = 1'b0;
      c.pc_we      = 1'b0;
      c.reg_we     = 1'b0;
      c.alu_out_we = 1'b0;
      c.mem_req    = 1'b0;
      c.mem_we     = 1'b0;
      c.retired    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= RESET_STATE;
      illegal_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE && !dec_legal)
        illegal_q <= 1'b1;
    end
  end

  assign ALUCtrl      = c.alu_ctrl;
  assign alu_src_a    = c.src_a;
  assign alu_src_b    = c.src_b;
  assign alu_out_we   = c.alu_out_we;
  assign ir_we        = c.ir_we;
  assign pc_we        = c.pc_we;
  assign pc_sel       = c.pc_sel;
  assign reg_we       = c.reg_we;
  assign wb_sel       = c.wb_sel;
  assign mem_req      = c.mem_req;
  assign mem_we       = c.mem_we;
  assign mem_addr_sel = c.mem_addr_sel;
  assign retired      = c.retired;
  assign illegal      = illegal_q;
  assign state        = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed RV32I instructions push expected EXEC and
// retire records; a negedge monitor pops and compares whenever the DUT strobes alu_out_we or retired.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zeroFlag, alu_lsb, mem_ready;
  logic [3:0]  ALUCtrl;
  logic [1:0]  alu_src_a, alu_src_b, pc_sel, wb_sel;
  logic        alu_out_we, ir_we, pc_we, reg_we, mem_req, mem_we, mem_addr_sel;
  logic        illegal, retired;
  logic [2:0]  state;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4020D193;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_BGEU = 32'h0020F463;
  localparam logic [31:0] I_LW   = 32'h0040A183;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_JALR = 32'h000100E7;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_AUIP = 32'h00001297;

  typedef struct {
    logic [3:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
  } exp_exec_t;

  typedef struct {
    logic [1:0] psel;
    logic       rwe;
    logic [1:0] wsel;
    int         lat;
    int         start;
  } exp_ret_t;

  exp_exec_t exq[$];
  exp_ret_t  rtq[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stall_cfg = 0;
  int mcnt = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .zeroFlag(zeroFlag), .alu_lsb(alu_lsb),
    .mem_ready(mem_ready), .ALUCtrl(ALUCtrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_out_we(alu_out_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .illegal(illegal), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: instruction fetches are zero-wait; data accesses hold ready low for stall_cfg cycles.
  always @(posedge clk) begin
    #2;
    if (mem_req === 1'b1 && mem_addr_sel === 1'b1) begin
      mem_ready = (mcnt >= stall_cfg);
      mcnt++;
    end else begin
      mem_ready = 1'b1;
      mcnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every EXEC cycle and every retire against the queued expectations.
  always @(negedge clk) begin
    exp_exec_t e;
    exp_ret_t  r;
    if (alu_out_we !== 1'b0) begin
      if (exq.size() == 0) begin
        check("exec_unexpected", {31'd0, alu_out_we}, 32'd0);
      end else begin
        e = exq.pop_front();
        check("exec_aluctrl", {28'd0, ALUCtrl}, {28'd0, e.alu});
        check("exec_src_a", {30'd0, alu_src_a}, {30'd0, e.sa});
        check("exec_src_b", {30'd0, alu_src_b}, {30'd0, e.sb});
      end
    end
    if (retired !== 1'b0) begin
      if (rtq.size() == 0) begin
        check("retire_unexpected", {31'd0, retired}, 32'd0);
      end else begin
        r = rtq.pop_front();
        check("ret_pc_we", {31'd0, pc_we}, 32'd1);
        check("ret_pc_sel", {30'd0, pc_sel}, {30'd0, r.psel});
        check("ret_reg_we", {31'd0, reg_we}, {31'd0, r.rwe});
        if (r.rwe) check("ret_wb_sel", {30'd0, wb_sel}, {30'd0, r.wsel});
        check("ret_latency", cyc - r.start + 1, r.lat);
      end
    end
  end

  // Called at posedge+1 of a FETCH cycle: loads the instruction and queues its expectations.
  task automatic expect_instr(input logic [31:0] ins, input logic zf, input logic lsb,
                              input int stall, input logic [3:0] alu, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [1:0] psel, input logic rwe,
                              input logic [1:0] wsel, input int lat);
    exp_exec_t e;
    exp_ret_t  r;
    instr = ins; zeroFlag = zf; alu_lsb = lsb; stall_cfg = stall;
    e.alu = alu; e.sa = sa; e.sb = sb;
    exq.push_back(e);
    r.psel = psel; r.rwe = rwe; r.wsel = wsel; r.lat = lat; r.start = cyc;
    rtq.push_back(r);
  endtask

  task automatic wait_retire(input logic chk_mem, input logic exp_we);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (chk_mem && state == S_MEM) begin
        check("mem_req_hold", {31'd0, mem_req}, 32'd1);
        check("mem_addr_sel_hold", {31'd0, mem_addr_sel}, 32'd1);
        check("mem_we_hold", {31'd0, mem_we}, {31'd0, exp_we});
        check("mem_no_reg_we", {31'd0, reg_we}, 32'd0);
      end
      if (retired === 1'b1) seen = 1'b1;
    end
    if (!seen) check("retire_timeout", {31'd0, retired}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] strobes();
    return {ir_we, pc_we, reg_we, alu_out_we, mem_req, mem_we, retired};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; instr = 32'h0; zeroFlag = 1'b0; alu_lsb = 1'b0; mem_ready = 1'b1;

    @(negedge clk);
    check("reset_state", {29'd0, state}, {29'd0, S_FETCH});
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    check("reset_strobes", {25'd0, strobes()}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    expect_instr(I_ADD, 0, 0, 0, ALU_CTRL_ADD, SRC_A_RS1, SRC_B_RS2, PC_SEL_PC4, 1, WB_SEL_ALUREG, 4);
    wait_retire(0, 0);
    expect_instr(I_SUB, 0, 0, 0, ALU_CTRL_SUB, SRC_A_RS1, SRC_B_RS2, PC_SEL_PC4, 1, WB_SEL_ALUREG, 4);
    wait_retire(0, 0);
    expect_instr(I_SRAI, 0, 0, 0, ALU_CTRL_SRA, SRC_A_RS1, SRC_B_IMM, PC_SEL_PC4, 1, WB_SEL_ALUREG, 4);
    wait_retire(0, 0);
    expect_instr(I_SLT, 0, 0, 0, ALU_CTRL_SLT, SRC_A_RS1, SRC_B_RS2, PC_SEL_PC4, 1, WB_SEL_ALUREG, 4);
    wait_retire(0, 0);
    expect_instr(I_AND, 0, 0, 0, ALU_CTRL_AND, SRC_A_RS1, SRC_B_RS2, PC_SEL_PC4, 1, WB_SEL_ALUREG, 4);
    wait_retire(0, 0);
    expect_instr(I_BEQ, 1, 0, 0, ALU_CTRL_SUB, SRC_A_RS1, SRC_B_RS2, PC_SEL_ALU, 0, WB_SEL_ALUREG, 4);
    wait_retire(0, 0);
    expect_instr(I_BEQ, 0, 0, 0, ALU_CTRL_SUB, SRC_A_RS1, SRC_B_RS2, PC_SEL_PC4, 0, WB_SEL_ALUREG, 3);
    wait_retire(0, 0);
    expect_instr(I_BLT, 0, 1, 0, ALU_CTRL_SLT, SRC_A_RS1, SRC_B_RS2, PC_SEL_ALU, 0, WB_SEL_ALUREG, 4);
    wait_retire(0, 0);
    expect_instr(I_BGEU, 0, 1, 0, ALU_CTRL_SLTU, SRC_A_RS1, SRC_B_RS2, PC_SEL_PC4, 0, WB_SEL_ALUREG, 3);
    wait_retire(0, 0);
    expect_instr(I_LW, 0, 0, 3, ALU_CTRL_ADD, SRC_A_RS1, SRC_B_IMM, PC_SEL_PC4, 1, WB_SEL_MEM, 8);
    wait_retire(1, 0);
    expect_instr(I_LW, 0, 0, 0, ALU_CTRL_ADD, SRC_A_RS1, SRC_B_IMM, PC_SEL_PC4, 1, WB_SEL_MEM, 5);
    wait_retire(1, 0);
    expect_instr(I_SW, 0, 0, 0, ALU_CTRL_ADD, SRC_A_RS1, SRC_B_IMM, PC_SEL_PC4, 0, WB_SEL_ALUREG, 4);
    wait_retire(1, 1);
    expect_instr(I_JAL, 0, 0, 0, ALU_CTRL_ADD, SRC_A_PC, SRC_B_IMM, PC_SEL_ALUREG, 1, WB_SEL_PC4, 4);
    wait_retire(0, 0);
    expect_instr(I_JALR, 0, 0, 0, ALU_CTRL_ADD, SRC_A_RS1, SRC_B_IMM, PC_SEL_ALUREG_ALIGN, 1, WB_SEL_PC4, 4);
    wait_retire(0, 0);
    expect_instr(I_LUI, 0, 0, 0, ALU_CTRL_LUI, SRC_A_ZERO, SRC_B_IMM, PC_SEL_PC4, 1, WB_SEL_ALUREG, 4);
    wait_retire(0, 0);
    expect_instr(I_AUIP, 0, 0, 0, ALU_CTRL_AUIPC, SRC_A_PC, SRC_B_IMM, PC_SEL_PC4, 1, WB_SEL_ALUREG, 4);
    wait_retire(0, 0);

    // Illegal all-zero opcode: trap, sticky flag, no strobes until reset.
    instr = 32'h0; stall_cfg = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state != S_TRAP && n < 8);
    check("trap_state", {29'd0, state}, {29'd0, S_TRAP});
    for (int i = 0; i < 3; i++) begin
      check("trap_illegal", {31'd0, illegal}, 32'd1);
      check("trap_strobes", {25'd0, strobes()}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_instr(I_ADD, 0, 0, 0, ALU_CTRL_ADD, SRC_A_RS1, SRC_B_RS2, PC_SEL_PC4, 1, WB_SEL_ALUREG, 4);
    @(negedge clk);
    check("post_trap_state", {29'd0, state}, {29'd0, S_FETCH});
    check("post_trap_illegal", {31'd0, illegal}, 32'd0);
    wait_retire(0, 0);

    // Store abandoned by reset while stalled in S_MEM.
    begin
      exp_exec_t e;
      e.alu = ALU_CTRL_ADD; e.sa = SRC_A_RS1; e.sb = SRC_B_IMM;
      exq.push_back(e);
      instr = I_SW; stall_cfg = 10;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state != S_MEM && n < 8);
    check("st_mem_state", {29'd0, state}, {29'd0, S_MEM});
    check("st_mem_we", {31'd0, mem_we}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_pc_we", {31'd0, pc_we}, 32'd0);
    check("rst_retired", {31'd0, retired}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_instr(I_ADD, 0, 0, 0, ALU_CTRL_ADD, SRC_A_RS1, SRC_B_RS2, PC_SEL_PC4, 1, WB_SEL_ALUREG, 4);
    @(negedge clk);
    check("refetch_state", {29'd0, state}, {29'd0, S_FETCH});
    check("refetch_mem_req", {31'd0, mem_req}, 32'd1);
    check("refetch_addr_sel", {31'd0, mem_addr_sel}, 32'd0);
    wait_retire(0, 0);

    repeat (2) @(posedge clk);
    check("exec_queue_drained", exq.size(), 32'd0);
    check("retire_queue_drained", rtq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
